// File: rtl/clz_arbiter.sv
// Round-robin arbiter sharing one 64-bit leading-zero counter between NUM_REQ requesters.
// Two-stage pipeline: operand register, clz, result register; results tagged with requester id.
module clz_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ*64-1:0] req_data,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [6:0]            rsp_count,
    output logic                  rsp_zero,
    output logic [ID_W-1:0]       rsp_id,
    output logic                  busy
);

    logic            s1_valid_q, s1_valid_d;
    logic [63:0]     s1_data_q, s1_data_d;
    logic [ID_W-1:0] s1_id_q, s1_id_d;
    logic            s2_valid_q, s2_valid_d;
    logic [6:0]      s2_count_q, s2_count_d;
    logic            s2_zero_q, s2_zero_d;
    logic [ID_W-1:0] s2_id_q, s2_id_d;
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;

    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    win_id;
    logic [ID_W-1:0]    scan_id;
    logic               any_req;
    logic               s1_load, s2_load, accept;
    logic [6:0]         clz;

    // Grant depends only on req_valid and rr_ptr, never on downstream ready.
    always_comb begin
        grant   = '0;
        win_id  = '0;
        scan_id = '0;
        any_req = 1'b0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            scan_id = ID_W'((32'(rr_ptr_q) + k) % NUM_REQ);
            if (!any_req && req_valid[scan_id]) begin
                any_req        = 1'b1;
                grant[scan_id] = 1'b1;
                win_id         = scan_id;
            end
        end
    end

    assign s2_load   = s1_valid_q & (~s2_valid_q | rsp_ready);
    assign s1_load   = ~s1_valid_q | s2_load;
    assign accept    = any_req & s1_load;
    assign req_ready = grant & {NUM_REQ{s1_load & rst_n}};

    // Highest set bit wins since later iterations overwrite earlier ones.
    always_comb begin
        clz = 7'd64;
        for (int i = 0; i < 64; i++) begin
            if (s1_data_q[i]) begin
                clz = 7'(63 - i);
            end
        end
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_data_d  = s1_data_q;
        s1_id_d    = s1_id_q;
        rr_ptr_d   = rr_ptr_q;
        s2_valid_d = s2_valid_q;
        s2_count_d = s2_count_q;
        s2_zero_d  = s2_zero_q;
        s2_id_d    = s2_id_q;

        if (s1_load) begin
            s1_valid_d = accept;
            if (accept) begin
                s1_data_d = req_data[64*win_id +: 64];
                s1_id_d   = win_id;
                rr_ptr_d  = (win_id == ID_W'(NUM_REQ - 1)) ? '0 : win_id + ID_W'(1);
            end
        end

        if (s2_load) begin
            s2_valid_d = 1'b1;
            s2_count_d = clz;
            s2_zero_d  = clz[6];
            s2_id_d    = s1_id_q;
        end else if (rsp_ready) begin
            s2_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_id_q    <= '0;
            rr_ptr_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_count_q <= '0;
            s2_zero_q  <= 1'b0;
            s2_id_q    <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            s1_id_q    <= s1_id_d;
            rr_ptr_q   <= rr_ptr_d;
            s2_valid_q <= s2_valid_d;
            s2_count_q <= s2_count_d;
            s2_zero_q  <= s2_zero_d;
            s2_id_q    <= s2_id_d;
        end
    end

    assign rsp_valid = s2_valid_q;
    assign rsp_count = s2_count_q;
    assign rsp_zero  = s2_zero_q;
    assign rsp_id    = s2_id_q;
    assign busy      = s1_valid_q | s2_valid_q;

endmodule

// File: tb/tb_clz_arbiter.sv
// Self-checking bench for clz_arbiter: directed vectors and sequences plus a randomised
// run against a queue-based scoreboard that owns arbitration order and clz arithmetic.
module tb_clz_arbiter;

    localparam int NR = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NR-1:0] req_valid;
    logic [63:0]   dat [NR];
    logic [NR*64-1:0] req_data;
    logic [NR-1:0] req_ready;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [6:0]    rsp_count;
    logic          rsp_zero;
    logic [1:0]    rsp_id;
    logic          busy;

    assign req_data = {dat[3], dat[2], dat[1], dat[0]};

    clz_arbiter #(.NUM_REQ(NR)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_count (rsp_count),
        .rsp_zero  (rsp_zero),
        .rsp_id    (rsp_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int pops   = 0;
    bit chk_lat = 1'b0;

    typedef struct {int id; int cnt; int cyc;} sb_t;
    sb_t sb[$];
    int  exp_ptr = 0;

    typedef struct {logic [63:0] op; int cnt; bit zero;} vec_t;
    vec_t vecs[7];

    task automatic chk(input string name, input longint got, input longint want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    // Reference count: walk down from bit 63 while the bit is zero.
    function automatic int ref_clz(input logic [63:0] d);
        int n = 0;
        while (n < 64 && d[63-n] == 1'b0) n++;
        return n;
    endfunction

    function automatic logic [63:0] rnd_op();
        logic [63:0] v;
        v = {$urandom, $urandom};
        return v >> $urandom_range(0, 64);
    endfunction

    always @(posedge clk) cyc++;

    // Scoreboard monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            exp_ptr = 0;
        end else begin
            int ew;
            int j;
            chk("ready_onehot", ($countones(req_ready) <= 1), 1);
            if (rsp_valid && rsp_ready) begin
                pops++;
                if (sb.size() == 0) begin
                    chk("spurious_rsp", 1, 0);
                end else begin
                    sb_t e;
                    e = sb.pop_front();
                    chk("rsp_count", rsp_count, e.cnt);
                    chk("rsp_zero", rsp_zero, (e.cnt == 64));
                    chk("rsp_id", rsp_id, e.id);
                    if (chk_lat) chk("latency", cyc - e.cyc, 2);
                end
            end
            if (req_ready != '0) begin
                ew = -1;
                for (int k = 0; k < NR; k++) begin
                    if (ew < 0 && req_valid[(exp_ptr + k) % NR]) ew = (exp_ptr + k) % NR;
                end
                chk("grant_rr", req_ready, (ew < 0) ? 0 : (1 << ew));
                j = -1;
                for (int i = NR - 1; i >= 0; i--) if (req_ready[i] && req_valid[i]) j = i;
                if (j >= 0) begin
                    sb.push_back('{id: j, cnt: ref_clz(dat[j]), cyc: cyc});
                    exp_ptr = (j + 1) % NR;
                end
            end
        end
    end

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic drain();
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input int id);
        bit ok = 1'b0;
        for (int t = 0; t < 20 && !ok; t++) begin
            @(negedge clk);
            if (req_ready[id]) ok = 1'b1;
        end
        if (!ok) chk("ready_timeout", 0, 1);
    endtask

    task automatic wait_rsp();
        bit ok = 1'b0;
        for (int t = 0; t < 20 && !ok; t++) begin
            @(negedge clk);
            if (rsp_valid) ok = 1'b1;
        end
        if (!ok) chk("rsp_timeout", 0, 1);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        int n;
        int p0;
        logic [NR-1:0] r;
        logic [NR-1:0] acc;
        int ids[$];

        vecs[0] = '{op: 64'h8000_0000_0000_0000, cnt: 0,  zero: 1'b0};
        vecs[1] = '{op: 64'h0000_0001_0000_0000, cnt: 31, zero: 1'b0};
        vecs[2] = '{op: 64'h0000_0000_0000_0000, cnt: 64, zero: 1'b1};
        vecs[3] = '{op: 64'hFFFF_FFFF_FFFF_FFFF, cnt: 0,  zero: 1'b0};
        vecs[4] = '{op: 64'h0000_0000_0000_00FF, cnt: 56, zero: 1'b0};
        vecs[5] = '{op: 64'h0100_0000_0000_0001, cnt: 7,  zero: 1'b0};
        vecs[6] = '{op: 64'h0000_0000_0000_0001, cnt: 63, zero: 1'b0};

        for (int i = 0; i < NR; i++) dat[i] = '0;
        do_reset();
        chk("reset_outputs", {rsp_valid, rsp_count, rsp_zero, rsp_id, busy}, 0);

        // Constant vectors through requester 1.
        rsp_ready = 1'b1;
        for (int v = 0; v < 7; v++) begin
            dat[1]    = vecs[v].op;
            req_valid = 4'b0010;
            wait_ready(1);
            @(posedge clk);
            #1 req_valid = '0;
            wait_rsp();
            chk("vec_count", rsp_count, vecs[v].cnt);
            chk("vec_zero", rsp_zero, vecs[v].zero);
            chk("vec_id", rsp_id, 1);
        end
        drain();

        // Asynchronous reset with both stages full.
        do_reset();
        for (int i = 0; i < NR; i++) dat[i] = 64'h0F00 << i;
        req_valid = 4'hF;
        repeat (4) @(posedge clk);
        #1 chk("full_before_reset", {busy, rsp_valid}, 2'b11);
        #1 rst_n = 1'b0;
        #1;
        chk("async_reset_rsp", {rsp_valid, rsp_count, rsp_zero, rsp_id}, 0);
        chk("async_reset_busy", busy, 0);
        chk("async_reset_ready", req_ready, 0);
        dat[0] = 64'h1;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_grant", req_ready, 4'b0001);
        @(posedge clk);
        #1 req_valid = '0;
        rsp_ready = 1'b1;
        wait_rsp();
        chk("post_reset_count", rsp_count, 63);
        chk("post_reset_id", rsp_id, 0);
        drain();

        // Single requester sweep with latency checking.
        do_reset();
        rsp_ready = 1'b1;
        chk_lat   = 1'b1;
        p0        = pops;
        req_valid = 4'b0100;
        for (int i = 0; i <= 64; i++) begin
            dat[2] = (i < 64) ? (64'h1 << i) : 64'h0;
            wait_ready(2);
            @(posedge clk);
            #1;
        end
        drain();
        chk_lat = 1'b0;
        chk("sweep_rsp_total", pops - p0, 65);

        // Round-robin with all requesters valid.
        do_reset();
        for (int i = 0; i < NR; i++) dat[i] = 64'h1 << (60 + i);
        rsp_ready = 1'b1;
        req_valid = 4'hF;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            chk("rr_order", req_ready, 1 << (k % NR));
        end
        @(posedge clk);
        #1 drain();

        // Back-pressure: two acceptances then stall.
        do_reset();
        dat[0]    = 64'h10;
        dat[1]    = 64'h100;
        req_valid = 4'b0011;
        n = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n += $countones(req_ready);
            r = req_ready;
        end
        chk("bp_accepts", n, 2);
        chk("bp_ready_low", r, 0);
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        for (int t = 0; t < 10 && ids.size() < 2; t++) begin
            @(negedge clk);
            if (rsp_valid) ids.push_back(int'(rsp_id));
        end
        chk("bp_rsp_n", ids.size(), 2);
        if (ids.size() == 2) begin
            chk("bp_first_id", ids[0], 0);
            chk("bp_second_id", ids[1], 1);
        end
        @(posedge clk);
        #1 drain();

        // Sparse valids alternate without idle cycles.
        do_reset();
        rsp_ready = 1'b1;
        req_valid = 4'b1010;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("sparse_grant", req_ready, (k % 2 == 0) ? 4'b0010 : 4'b1000);
        end
        @(posedge clk);
        #1 drain();

        // Randomised traffic honouring the hold-until-accepted contract.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            acc = req_valid & req_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < NR; i++) begin
                if (!req_valid[i] || acc[i]) begin
                    req_valid[i] = ($urandom_range(0, 1) == 1);
                    dat[i]       = rnd_op();
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
        end
        drain();
        chk("random_drained", sb.size(), 0);
        chk("random_idle", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/clz_arbiter.md
# clz_arbiter

Shares one 64-bit leading-zero counter between up to eight FPU requesters, for example the add/sub normaliser, the int-to-float converter and the multiplier normaliser. Requests use a valid/ready handshake and are arbitrated round-robin. The winning operand passes through a two-stage pipeline: an operand register, then the single combinational `clz_64` count, then a result register. Each result returns tagged with the requester index, and back-pressure is supported on the response side.

## Interface
- `NUM_REQ`, default 4: number of requesters; legal range 2..8.
- `ID_W`, default `$clog2(NUM_REQ)`: width of the requester tag; derived, never overridden.

- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous and active-low; synchronous deassertion is the integrator's responsibility.
- `req_valid` input `NUM_REQ`: bit i means requester i presents an operand.
- `req_data` input `NUM_REQ*64`: operand of requester i in bits `[64*i+63 : 64*i]`.
- `req_ready` output `NUM_REQ`: bit i means requester i's operand is accepted this cycle.
- `rsp_valid` output 1: a result is held in the result register.
- `rsp_ready` input 1: the consumer accepts the result this cycle.
- `rsp_count` output 7: leading-zero count, range 0..64.
- `rsp_zero` output 1: the operand was all zeros (`rsp_count == 64`).
- `rsp_id` output `ID_W`: index of the requester that owns the result.
- `busy` output 1: either pipeline stage holds a valid entry.

## Operation
- **Stage S1 (operand register):** holds `s1_valid`, `s1_data[63:0]` and `s1_id`.
- **Stage S2 (result register):** holds `s2_valid`, `s2_count[6:0]` and `s2_id`. These drive `rsp_valid`, `rsp_count` and `rsp_id` directly.
  - `rsp_zero` is registered alongside the count, not decoded from the output.
- **Advance conditions:**
  - `s2_load = s1_valid & (~s2_valid | rsp_ready)`
  - `s1_load = ~s1_valid | s2_load`
- **Arbitration:** round-robin with pointer `rr_ptr` (`ID_W` bits).
  - The winner is the first i with `req_valid[i]` set, scanning from `rr_ptr` upward and wrapping modulo `NUM_REQ`.
  - `grant` is combinational from `req_valid` and `rr_ptr` only. It never depends on `rsp_ready`-derived ready, so there is no valid/ready loop.
  - `req_ready[i] = grant[i] & s1_load`. At most one bit of `req_ready` is set in any cycle.
- **On acceptance** (any `req_valid[i] & req_ready[i]`):
  - S1 captures the operand and id, and `s1_valid` is set to 1.
  - `rr_ptr` becomes winner+1, wrapping to 0 after `NUM_REQ-1`.
- **No acceptance with `s1_load` true:** `s1_valid` is set to 0 and `rr_ptr` is held.
- **On `s2_load`:** S2 captures the `clz_64` result of `s1_data`, `s1_id`, and `rsp_zero = count[6]`.
- **S2 drain without load:** if `rsp_ready & ~s2_load`, then `s2_valid` is set to 0.
- **Count arithmetic:**
  - The count is the number of zero bits above the most significant 1, with bit 63 as MSB.
  - An all-zero operand gives 64.
  - A count of 64 is the only value with bit 6 set.
- **Requester contract:** a requester must hold `req_valid` and `req_data` stable until accepted. The block tolerates violations but makes no guarantee about the result.
- **Skipping requesters:** a requester whose `req_valid` is low is skipped with no penalty cycle.
- **`busy`:** `s1_valid | s2_valid`.

## Timing
- **Reset values** (immediately on `rst_n` low, independent of `clk`):
  - `s1_valid = 0`, `s2_valid = 0`, `rr_ptr = 0`
  - `s1_data = 0`, `s1_id = 0`
  - `rsp_valid = 0`, `rsp_count = 0`, `rsp_zero = 0`, `rsp_id = 0`
  - `busy = 0`, `req_ready = 0`
- **Reset mid-operation:** in-flight entries are discarded without a response. The first post-reset grant favours requester 0.
- **Latency:** accept in cycle N gives `rsp_valid` high in cycle N+2 when unstalled.
- **Throughput:** one result per cycle with `rsp_ready` held high.
- **Stall:** with `rsp_valid=1` and `rsp_ready=0`:
  - S2 holds.
  - S1 may fill one more entry, then all `req_ready` are 0.
  - There is no loss and no duplication.
- **Stall release:** on the first `rsp_ready=1`:
  - S2 takes the S1 entry.
  - S1 accepts a new request in the same cycle.
  - Full throughput resumes with no bubble.
- **Simultaneous events:**
  - Response pop and new acceptance in the same cycle are both legal.
  - Pop with S1 empty leaves `rsp_valid=0` next cycle.
- **Fairness:** with all requesters valid continuously, each is granted exactly once every `NUM_REQ` accepted transfers.

## Test plan
- **Reset:**
  - Stimulus: assert `rst_n=0` mid-stream with both stages full.
  - Required: all outputs go to 0 asynchronously.
  - Required after release: requester 0 with `req_data=64'h1` is accepted first and returns `rsp_count=63`, `rsp_id=0`.
- **Single requester sweep:**
  - Stimulus: requester 2 sends `1<<i` for i=0..63, then 0, with `rsp_ready=1`.
  - Required: counts are 63..0 then 64, in order, each 2 cycles after acceptance.
  - Required: `rsp_zero=1` only for the final operand.
  - Required: `rsp_id=2` throughout.
- **Round-robin:**
  - Stimulus: all 4 requesters valid continuously, with requester i sending `64'h1<<(60+i)`.
  - Required: grant order 0,1,2,3,0,…
  - Required: `rsp_count` sequence 3,2,1,0,3,…
- **Back-pressure:**
  - Stimulus: hold `rsp_ready=0` for 5 cycles with requesters 0 and 1 valid.
  - Required: exactly 2 acceptances, then `req_ready=0`.
  - Required on release: results emerge in acceptance order with correct ids and no duplicates.
- **Sparse valid:**
  - Stimulus: only requesters 1 and 3 valid, `rr_ptr=0`.
  - Required: grants alternate 1,3,1,3 with no idle cycles.
- **Randomised:**
  - Stimulus: random valids, operands and `rsp_ready`, checked against a scoreboard.
  - Required: every accepted operand yields exactly one response with the correct count and id.
  - Required: at most one `req_ready` bit is high per cycle.
